// File: rtl/bht_port_sched_pkg.sv
// Shared defaults and grant encoding for the branch-history-table port scheduler.
package bht_port_sched_pkg;
  localparam int DEF_ADDR_W     = 7;
  localparam int DEF_HIST_W     = 10;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_STARVE_MAX = 3;

  typedef enum logic [1:0] {
    GNT_IDLE  = 2'd0,
    GNT_LOOK  = 2'd1,
    GNT_DRAIN = 2'd2
  } grant_e;
endpackage

// File: rtl/bht_port_sched_if.sv
// Lookup, update and table-port signals of the scheduler; slave = scheduler side.
interface bht_port_sched_if
  import bht_port_sched_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int HIST_W = DEF_HIST_W,
  parameter int DEPTH  = DEF_DEPTH
) ();
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              lk_valid;
  logic [ADDR_W-1:0] lk_addr;
  logic              lk_ready;
  logic              lk_hist_valid;
  logic [HIST_W-1:0] lk_hist;
  logic              lk_stale;
  logic              up_valid;
  logic [ADDR_W-1:0] up_addr;
  logic              up_taken;
  logic              up_ready;
  logic [ADDR_W-1:0] tab_addr;
  logic              tab_wr_en;
  logic              tab_wr_data;
  logic [HIST_W-1:0] tab_rd_data;
  logic [CNT_W-1:0]  fifo_cnt;

  modport slave (
    input  lk_valid, lk_addr, up_valid, up_addr, up_taken, tab_rd_data,
    output lk_ready, lk_hist_valid, lk_hist, lk_stale, up_ready,
           tab_addr, tab_wr_en, tab_wr_data, fifo_cnt
  );

  modport master (
    output lk_valid, lk_addr, up_valid, up_addr, up_taken, tab_rd_data,
    input  lk_ready, lk_hist_valid, lk_hist, lk_stale, up_ready,
           tab_addr, tab_wr_en, tab_wr_data, fifo_cnt
  );
endinterface

// File: rtl/bht_upd_fifo.sv
// Circular buffer of pending history updates with a parallel address match
// over the occupied slots.
module bht_upd_fifo
  import bht_port_sched_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic              push_taken,
  input  logic              pop,
  output logic [ADDR_W-1:0] head_addr,
  output logic              head_taken,
  output logic [CNT_W-1:0]  cnt,
  input  logic [ADDR_W-1:0] match_addr,
  output logic              match
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              taken;
  } upd_t;

  upd_t             mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [DEPTH-1:0] hit;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CNT_W'(push) - CNT_W'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{addr: push_addr, taken: push_taken};
  end

  // A slot is live when its distance from the head is below the occupancy.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign hit[g] = (CNT_W'(PTR_W'(g) - rd_ptr) < cnt) && (mem[g].addr == match_addr);
  end

  assign match      = |hit;
  assign head_addr  = mem[rd_ptr].addr;
  assign head_taken = mem[rd_ptr].taken;
endmodule

// File: rtl/bht_port_sched.sv
// Arbitrates the single table address port between predict lookups and
// buffered commit updates, with starvation and full-FIFO forced drains.
module bht_port_sched
  import bht_port_sched_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int HIST_W     = DEF_HIST_W,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic            clk,
  input  logic            reset,
  bht_port_sched_if.slave bus
);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int ST_W  = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  grant_e            grant;
  logic [ST_W-1:0]   starve;
  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W-1:0] head_addr;
  logic              head_taken;
  logic              match;
  logic              push, pop, pending, full;

  assign pending = (cnt != '0);
  assign full    = (cnt == CNT_W'(DEPTH));

  always_comb begin
    grant = GNT_IDLE;
    if (reset)                                          grant = GNT_IDLE;
    else if (full)                                      grant = GNT_DRAIN;
    else if (pending && starve == ST_W'(STARVE_MAX))    grant = GNT_DRAIN;
    else if (bus.lk_valid)                              grant = GNT_LOOK;
    else if (pending)                                   grant = GNT_DRAIN;
  end

  assign bus.up_ready = !reset && !full;
  assign push         = bus.up_valid && bus.up_ready;
  assign pop          = (grant == GNT_DRAIN);
  assign bus.lk_ready = (grant == GNT_LOOK);
  assign bus.fifo_cnt = cnt;

  always_comb begin
    bus.tab_addr    = '0;
    bus.tab_wr_en   = 1'b0;
    bus.tab_wr_data = 1'b0;
    case (grant)
      GNT_LOOK:  bus.tab_addr = bus.lk_addr;
      GNT_DRAIN: begin
        bus.tab_addr    = head_addr;
        bus.tab_wr_en   = 1'b1;
        bus.tab_wr_data = head_taken;
      end
      default: ;
    endcase
  end

  // Counts cycles a non-empty FIFO was denied the port; an empty FIFO owes nothing.
  always_ff @(posedge clk) begin
    if (reset || pop || !pending)             starve <= '0;
    else if (starve != ST_W'(STARVE_MAX))     starve <= starve + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bus.lk_hist_valid <= 1'b0;
      bus.lk_hist       <= '0;
      bus.lk_stale      <= 1'b0;
    end else begin
      bus.lk_hist_valid <= (grant == GNT_LOOK);
      if (grant == GNT_LOOK) begin
        bus.lk_hist  <= bus.tab_rd_data;
        bus.lk_stale <= match;
      end
    end
  end

  bht_upd_fifo #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_addr  (bus.up_addr),
    .push_taken (bus.up_taken),
    .pop        (pop),
    .head_addr  (head_addr),
    .head_taken (head_taken),
    .cnt        (cnt),
    .match_addr (bus.lk_addr),
    .match      (match)
  );
endmodule
